vc_pop_scheduler: RTL and testbench
===================================

// Module: vc_pop_scheduler
// PURPOSE
//  Sequences the egress of two virtual-channel FIFOs (VC0, VC1) into two destination FIFOs (D0, D1).
//  Each cycle it grants at most one VC pop, steers the popped word to D0 or D1 by its destination bit,
//  and stalls while either destination signals pause. VC0 has priority; an optional guard bounds VC1 starvation.
//  Sits between the VC FIFO bank and the destination FIFO bank, replacing ad-hoc pop logic with a registered FSM.
// PARAMETERS
//  DATA_W      6   word width of VC/destination FIFO data
//  DEST_BIT    4   bit index of data word selecting destination (0 -> D0, 1 -> D1); must be < DATA_W
//  RESUME_DLY  2   consecutive cycles pause must stay low before leaving PAUSE (1..15)
//  MAX_BURST   4   consecutive VC0 grants allowed while VC1 waits (guard only; 1..15)
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  vc0_empty   in   1       VC0 FIFO empty
//  vc1_empty   in   1       VC1 FIFO empty
//  vc0_data    in   DATA_W  VC0 FIFO head word (valid when !vc0_empty)
//  vc1_data    in   DATA_W  VC1 FIFO head word (valid when !vc1_empty)
//  d0_pause    in   1       D0 almost-full
//  d1_pause    in   1       D1 almost-full
//  pop_vc0     out  1       pop VC0 this cycle (combinational)
//  pop_vc1     out  1       pop VC1 this cycle (combinational)
//  push_d0     out  1       push data_out into D0 (registered)
//  push_d1     out  1       push data_out into D1 (registered)
//  data_out    out  DATA_W  word for destination FIFOs (registered)
//  state       out  2       FSM state: 00 IDLE, 01 ACTIVE, 10 PAUSE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset (async assert, sync to clk edge on release): state=IDLE, push_d0=push_d1=0, data_out=0,
//   resume counter=0, burst counter=0; pop_vc0=pop_vc1=0 while reset high.
//  pause_any = d0_pause | d1_pause; has_data = !vc0_empty | !vc1_empty.
//  FSM (registered, one transition per clk):
//   IDLE:   pause_any -> PAUSE; else has_data -> ACTIVE; else stay. No pops in IDLE.
//   ACTIVE: pause_any -> PAUSE; else !has_data -> IDLE; else stay.
//   PAUSE:  resume counter increments each cycle pause_any=0, clears on pause_any=1;
//           counter reaching RESUME_DLY -> ACTIVE if has_data else IDLE; counter clears on exit.
//  Grant (combinational): only when state==ACTIVE && !pause_any; at most one of pop_vc0/pop_vc1 high.
//   Default: pop_vc0 = !vc0_empty; pop_vc1 = vc0_empty & !vc1_empty.
//   Never pop an empty VC; pause rising in ACTIVE blocks pops in that same cycle.
//  Steering: on any pop, next cycle data_out = popped word; push_d0 = !word[DEST_BIT],
//   push_d1 = word[DEST_BIT]; exactly one push per pop, latency 1 cycle. No pop -> both pushes 0,
//   data_out holds.
//  Throughput: 1 word/cycle in ACTIVE; IDLE->ACTIVE entry costs 1 cycle before first pop.
//  Pause asserted in the cycle after a pop does not cancel that pop's push (destination pause
//   threshold must leave >=1 slot of headroom).
// CONFIGURATION
//  VC_POP_STARVE_GUARD_EN defined: burst counter ($clog2(MAX_BURST+1) bits) counts consecutive
//   pop_vc0 while !vc1_empty; when count==MAX_BURST and !vc1_empty, next grant goes to VC1
//   (pop_vc1=1, pop_vc0=0) and counter clears. Counter also clears on any pop_vc1 or when vc1_empty;
//   holds during PAUSE/IDLE.
//  Not defined: counter absent, strict VC0 priority as in Grant default.
// TESTING
//  Reset mid-ACTIVE with both VCs non-empty -> pops drop same cycle, state=00, pushes 0 next edge.
//  VC0 holds 3 words (DEST bit 0,1,0), VC1 empty, no pause -> IDLE, ACTIVE, 3 consecutive pop_vc0;
//   push_d0,push_d1,push_d0 one cycle later with matching data_out; then state back to IDLE.
//  d1_pause pulses high during ACTIVE, RESUME_DLY=2 -> pops stop same cycle, state=PAUSE,
//   resumes pops exactly 2 cycles after pause falls; pause re-rising at cycle 1 restarts count.
//  Both VCs hold 10 words, guard off -> all 10 VC0 words pop before any VC1 pop.
//  Same with VC_POP_STARVE_GUARD_EN, MAX_BURST=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1,...
//  VC0 and VC1 become empty on same cycle as last pop -> no pop of empty VC, state->IDLE next edge.

Source files
------------

// File: rtl/vc_pop_scheduler.sv
// vc_pop_scheduler: grants one VC FIFO pop per cycle and steers the word to D0/D1
//   Optional starvation guard is enabled with `define VC_POP_STARVE_GUARD_EN.
//   Ports:
//     clk, reset (async, active-high)
//     vc0_empty, vc1_empty, vc0_data, vc1_data : VC FIFO heads
//     d0_pause, d1_pause                       : destination almost-full
//     pop_vc0, pop_vc1                         : combinational pop grants
//     push_d0, push_d1, data_out               : registered destination write
//     state                                    : 00 IDLE, 01 ACTIVE, 10 PAUSE
module vc_pop_scheduler #(
  parameter int DATA_W     = 6,
  parameter int DEST_BIT   = 4,
  parameter int RESUME_DLY = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_pause,
  input  logic              d1_pause,
  output logic              pop_vc0,
  output logic              pop_vc1,
  output logic              push_d0,
  output logic              push_d1,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        state
);
  localparam logic [1:0] IDLE = 2'b00, ACTIVE = 2'b01, PAUSE = 2'b10;
  logic [1:0] next_state;
  logic [3:0] resume_cnt;
  logic [DATA_W-1:0] word;
  logic pause_any, has_data, grant_ok, force_vc1, resume_done, pop_any;
  assign pause_any = d0_pause | d1_pause;
  assign has_data = !vc0_empty | !vc1_empty;
  assign grant_ok = state == ACTIVE && !pause_any;
  // the counter value seen this cycle plus the current quiet cycle reaches RESUME_DLY
  assign resume_done = !pause_any && resume_cnt == 4'(RESUME_DLY - 1);
`ifdef VC_POP_STARVE_GUARD_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt;
  assign force_vc1 = burst_cnt == BW'(MAX_BURST) && !vc1_empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) burst_cnt <= '0;
    else if (vc1_empty || pop_vc1) burst_cnt <= '0;
    else if (pop_vc0) burst_cnt <= burst_cnt + 1'b1;
`else
  assign force_vc1 = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // IDLE and ACTIVE share the same transition rules
  always_comb
    next_state = state == PAUSE ? (resume_done ? (has_data ? ACTIVE : IDLE) : PAUSE)
               : pause_any ? PAUSE : has_data ? ACTIVE : IDLE;
  always_comb begin
    pop_vc1 = grant_ok && !vc1_empty && (vc0_empty || force_vc1);
    pop_vc0 = grant_ok && !vc0_empty && !force_vc1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) resume_cnt <= '0;
    else resume_cnt <= (state != PAUSE || pause_any || resume_done) ? 4'd0 : resume_cnt + 4'd1;
  assign pop_any = pop_vc0 | pop_vc1;
  assign word = pop_vc1 ? vc1_data : vc0_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_out <= '0;
    end else begin
      push_d0 <= pop_any & !word[DEST_BIT];
      push_d1 <= pop_any & word[DEST_BIT];
      if (pop_any) data_out <= word;
    end
endmodule

// File: tb/tb_vc_pop_scheduler.sv
// tb_vc_pop_scheduler: vector table, directed corner cases and randomized model comparison
module tb_vc_pop_scheduler;
  localparam int DW = 6, DB = 4, RD = 2, MB = 4;
`ifdef VC_POP_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic vc0_empty, vc1_empty, d0_pause, d1_pause;
  logic [DW-1:0] vc0_data, vc1_data, data_out;
  logic pop_vc0, pop_vc1, push_d0, push_d1;
  logic [1:0] state;
  int checks = 0, errors = 0;

  vc_pop_scheduler #(.DATA_W(DW), .DEST_BIT(DB), .RESUME_DLY(RD), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data), .d0_pause(d0_pause), .d1_pause(d1_pause),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .state(state));

  always #5 clk = ~clk;

  typedef struct {
    bit e0, e1;
    logic [DW-1:0] a, b;
    bit p0, p1, x0, x1;
    logic [1:0] xs;
    bit q0, q1;
    logic [DW-1:0] xd;
  } vec_t;

  vec_t tbl[20];
  logic [DW-1:0] q0[$], q1[$];
  int grants[$];

  function automatic vec_t mk(bit e0, bit e1, logic [DW-1:0] a, logic [DW-1:0] b, bit p0, bit p1,
                              bit x0, bit x1, logic [1:0] xs, bit q0, bit q1, logic [DW-1:0] xd);
    vec_t v;
    v.e0 = e0; v.e1 = e1; v.a = a; v.b = b; v.p0 = p0; v.p1 = p1;
    v.x0 = x0; v.x1 = x1; v.xs = xs; v.q0 = q0; v.q1 = q1; v.xd = xd;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit e0, bit e1, logic [DW-1:0] a, logic [DW-1:0] b, bit p0, bit p1);
    vc0_empty = e0; vc1_empty = e1; vc0_data = a; vc1_data = b; d0_pause = p0; d1_pause = p1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // drive VC heads from the tb queues and record which VC was granted
  task automatic queue_cycle(bit p0, bit p1);
    @(negedge clk);
    drive(q0.size() == 0, q1.size() == 0, q0.size() ? q0[0] : DW'($urandom),
          q1.size() ? q1[0] : DW'($urandom), p0, p1);
    #1;
    if (pop_vc0 && pop_vc1) chk("double_pop", 1, 0);
    if (pop_vc0) begin
      if (q0.size() == 0) chk("pop_empty_vc0", 1, 0); else void'(q0.pop_front());
      grants.push_back(0);
    end
    if (pop_vc1) begin
      if (q1.size() == 0) chk("pop_empty_vc1", 1, 0); else void'(q1.pop_front());
      grants.push_back(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_push_d0", push_d0, 0);
    chk("rst_push_d1", push_d1, 0);
    chk("rst_data", data_out, 0);
    chk("rst_pop_vc0", pop_vc0, 0);
    @(negedge clk);
    reset = 1'b0;

    // three VC0 words, then pause pulses with a restarted resume count, then a VC1 word
    tbl[0]  = mk(0, 1, 6'h03, 6'h00, 0, 0, 0, 0, 2'd0, 0, 0, 6'h00);
    tbl[1]  = mk(0, 1, 6'h03, 6'h00, 0, 0, 1, 0, 2'd1, 1, 0, 6'h03);
    tbl[2]  = mk(0, 1, 6'h15, 6'h00, 0, 0, 1, 0, 2'd1, 0, 1, 6'h15);
    tbl[3]  = mk(0, 1, 6'h0A, 6'h00, 0, 0, 1, 0, 2'd1, 1, 0, 6'h0A);
    tbl[4]  = mk(1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 2'd1, 0, 0, 6'h0A);
    tbl[5]  = mk(1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 2'd0, 0, 0, 6'h0A);
    tbl[6]  = mk(0, 1, 6'h01, 6'h00, 0, 0, 0, 0, 2'd0, 0, 0, 6'h0A);
    tbl[7]  = mk(0, 1, 6'h01, 6'h00, 0, 0, 1, 0, 2'd1, 1, 0, 6'h01);
    tbl[8]  = mk(0, 1, 6'h02, 6'h00, 0, 1, 0, 0, 2'd1, 0, 0, 6'h01);
    tbl[9]  = mk(0, 1, 6'h02, 6'h00, 0, 0, 0, 0, 2'd2, 0, 0, 6'h01);
    tbl[10] = mk(0, 1, 6'h02, 6'h00, 0, 1, 0, 0, 2'd2, 0, 0, 6'h01);
    tbl[11] = mk(0, 1, 6'h02, 6'h00, 0, 0, 0, 0, 2'd2, 0, 0, 6'h01);
    tbl[12] = mk(0, 1, 6'h02, 6'h00, 0, 0, 0, 0, 2'd2, 0, 0, 6'h01);
    tbl[13] = mk(0, 1, 6'h02, 6'h00, 0, 0, 1, 0, 2'd1, 1, 0, 6'h02);
    tbl[14] = mk(1, 0, 6'h00, 6'h13, 1, 0, 0, 0, 2'd1, 0, 0, 6'h02);
    tbl[15] = mk(1, 0, 6'h00, 6'h13, 0, 0, 0, 0, 2'd2, 0, 0, 6'h02);
    tbl[16] = mk(1, 0, 6'h00, 6'h13, 0, 0, 0, 0, 2'd2, 0, 0, 6'h02);
    tbl[17] = mk(1, 0, 6'h00, 6'h13, 0, 0, 0, 1, 2'd1, 0, 1, 6'h13);
    tbl[18] = mk(1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 2'd1, 0, 0, 6'h13);
    tbl[19] = mk(1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 2'd0, 0, 0, 6'h13);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].e0, tbl[i].e1, tbl[i].a, tbl[i].b, tbl[i].p0, tbl[i].p1);
      #1;
      chk($sformatf("tbl%0d_pop_vc0", i), pop_vc0, tbl[i].x0);
      chk($sformatf("tbl%0d_pop_vc1", i), pop_vc1, tbl[i].x1);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].xs);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_push_d0", i), push_d0, tbl[i].q0);
      chk($sformatf("tbl%0d_push_d1", i), push_d1, tbl[i].q1);
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].xd);
    end

    // asynchronous reset while ACTIVE with both VCs holding data
    @(negedge clk);
    drive(0, 0, 6'h05, 6'h16, 0, 0);
    @(negedge clk);
    #1;
    chk("mid_pop_before", pop_vc0, 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_pop_vc0", pop_vc0, 0);
    chk("mid_rst_pop_vc1", pop_vc1, 0);
    chk("mid_rst_state", state, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_push_d0", push_d0, 0);
    chk("mid_rst_push_d1", push_d1, 0);
    chk("mid_rst_data", data_out, 0);
    @(negedge clk);
    reset = 1'b0;

    // both VCs hold 10 words: grant order against the priority/guard rule
    begin
      int n0, n1, run, g, cyc;
      for (int i = 0; i < 10; i++) begin
        q0.push_back(DW'($urandom));
        q1.push_back(DW'($urandom));
      end
      grants.delete();
      cyc = 0;
      while ((q0.size() || q1.size()) && cyc < 60) begin
        queue_cycle(0, 0);
        cyc++;
      end
      chk("starve_drained", q0.size() + q1.size(), 0);
      chk("starve_grant_count", grants.size(), 20);
      n0 = 10; n1 = 10; run = 0;
      for (int k = 0; k < 20 && k < grants.size(); k++) begin
        g = (GUARD && n1 > 0 && run == MB) ? 1 : (n0 > 0 ? 0 : 1);
        if (g == 1) begin n1--; run = 0; end
        else begin n0--; run = n1 > 0 ? run + 1 : 0; end
        chk($sformatf("starve_grant%0d", k), grants[k], g);
      end
      queue_cycle(0, 0);
      chk("drain_no_pop", int'(pop_vc0) + int'(pop_vc1), 0);
      chk("drain_state_active", state, 1);
      @(posedge clk);
      #1;
      chk("drain_state_idle", state, 0);
    end

    // randomized traffic against a reference model
    do_reset();
    q0.delete();
    q1.delete();
    begin
      int m_st, m_quiet, m_run;
      bit m_q0, m_q1, pa, hd, ok, g0, g1;
      logic [DW-1:0] m_dat, w;
      m_st = 0; m_quiet = 0; m_run = 0; m_q0 = 0; m_q1 = 0; m_dat = '0;
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(DW'($urandom));
        if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(DW'($urandom));
        drive(q0.size() == 0, q1.size() == 0, q0.size() ? q0[0] : DW'($urandom),
              q1.size() ? q1[0] : DW'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        #1;
        pa = d0_pause | d1_pause;
        hd = !vc0_empty | !vc1_empty;
        ok = m_st == 1 && !pa;
        g1 = ok && !vc1_empty && (vc0_empty || (GUARD && m_run == MB));
        g0 = ok && !vc0_empty && !g1;
        w = g1 ? vc1_data : vc0_data;
        chk("rnd_pop_vc0", pop_vc0, g0);
        chk("rnd_pop_vc1", pop_vc1, g1);
        chk("rnd_state", state, m_st);
        if (pop_vc0 && q0.size()) void'(q0.pop_front());
        if (pop_vc1 && q1.size()) void'(q1.pop_front());
        if (m_st == 2) begin
          m_quiet = pa ? 0 : m_quiet + 1;
          if (m_quiet == RD) begin m_st = hd ? 1 : 0; m_quiet = 0; end
        end else m_st = pa ? 2 : (hd ? 1 : 0);
        m_run = (vc1_empty || g1) ? 0 : (g0 ? m_run + 1 : m_run);
        m_q0 = (g0 || g1) && !w[DB];
        m_q1 = (g0 || g1) && w[DB];
        if (g0 || g1) m_dat = w;
        @(posedge clk);
        #1;
        chk("rnd_push_d0", push_d0, m_q0);
        chk("rnd_push_d1", push_d1, m_q1);
        chk("rnd_data", data_out, m_dat);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
